arb_rr4_ctrl: RTL and testbench
===============================

# arb_rr4_ctrl

Four-requester round-robin arbiter that shares a single downstream resource and drives its one-hot select through a 2-to-4 decoder stage. Requesters hold `req` for as long as they need the resource. The controller locks the grant until the owner releases or a hold-limit timer expires, then rotates priority. It sits in front of any 4-way shared datapath whose select lines come from `decoder_2to4`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership; legal range 1..255.
- `CNT_W`, default 8: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `arb_en` in 1: when low, no new grant is issued; an existing grant runs to release or timeout.
- `req` in 4: request vector, bit i = requester i; level-sensitive.
- `grant` out 4: one-hot grant, or 0000 when idle.
- `grant_idx` out 2: binary index of the current owner; valid only when `busy`=1, else 00.
- `busy` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse on the cycle the current grant is revoked by the hold limit.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, `grant`=0000, `grant_idx`=00, `busy`=0, `timeout`=0, hold count=0, priority pointer `last`=3 so requester 0 has top priority first.
- The winner search scans indices `last+1`, `last+2`, `last+3`, `last+4` (mod 4) and takes the first set `req` bit.
- IDLE:
  - If `arb_en`=1 and `req`≠0: register winner w into `grant_idx`, set count=1, go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - `grant` = decode(`grant_idx`, en=1); `busy`=1.
  - Release condition: `req[grant_idx]`=0.
  - Timeout condition: `req[grant_idx]`=1 and count==`MAX_HOLD`.
  - On release or timeout, `last` takes the value of `grant_idx`, and a new search runs from the updated `last` over the current `req`. On timeout the current owner's bit is included, so it wins only if no other bit is set.
  - If `arb_en`=1 and a winner exists: go directly to GRANT with the new index and count=1. Handover has no bubble.
  - Otherwise go to IDLE.
  - With neither release nor timeout: count increments and the grant holds.
- `timeout` is a registered output. It is 1 for exactly the cycle after the revoking edge, aligned with the new `grant` value, including a self re-grant.
- `arb_en` falling during GRANT has no effect until release or timeout. At that point the controller goes to IDLE regardless of pending requests.
- Requests from non-owners are ignored while a grant is held (lock semantics).
- `rst_n` low in any state overrides everything at the next edge. The grant is dropped and the pointer returns to 3.

## Timing
- Request to grant latency: 1 cycle. `req` is sampled at edge k and `grant` is visible after edge k.
- Release to next grant latency: 1 cycle. The owner's `req` low is sampled at edge k; after edge k the new owner is granted or `grant`=0000.
- Maximum continuous ownership: `MAX_HOLD` cycles.
- Worst-case wait for a continuously requesting requester: 3×`MAX_HOLD` cycles.
- All outputs are registered. There is no combinational path from `req` to `grant`.
- `grant` is always one-hot or zero; never more than one bit is set.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum (IDLE, GRANT);
  - `NUM_REQ`=4 and `IDX_W`=2;
  - a function implementing the rotate-and-first-set search.
- Sub-module: instantiate `decoder_2to4` with `in`=`grant_idx` and `en`=`busy` to produce `grant`. The decoder input and enable are registered, so `grant` is glitch-free.
- The remaining logic is a single module: FSM, pointer, hold counter and timeout register.

## Test plan
- Reset, then `req`=0001 → after 1 cycle `grant`=0001, `grant_idx`=00, `busy`=1. Drop `req` → next cycle `grant`=0000, `busy`=0.
- `req`=1111 held indefinitely with `MAX_HOLD`=4 → grants 0001, 0010, 0100, 1000, 0001, each for 4 cycles. `timeout` pulses at each change. No idle cycles between owners.
- Owner 2 holding, `req`=0101 with `last`=2. Requester 2 drops `req` → next cycle `grant`=0001. Wrap-around passes over index 3 because `req[3]`=0.
- `req`=0010 only, `MAX_HOLD`=4 → `grant`=0010 continuously. `timeout` pulses every 4 cycles (self re-grant, count resets).
- Owner 1 holding, `arb_en` drops to 0, `req`=1010. Requester 1 releases → `grant`=0000 and stays 0000 until `arb_en`=1. Then after 1 cycle `grant`=1000.
- `rst_n` asserted low for 1 cycle mid-grant with `req`=0100 held → `grant`=0000 after the reset edge. Next cycle `grant`=0100, proving pointer reset to 3 and the search restarted from requester 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Holds FSM states, sizes and the rotate-and-first-set search.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan last+1 .. last+4 (mod 4) and return the first set bit.
  // The loop walks backwards so the nearest hit is written last.
  function automatic pick_t rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   last
  );
    pick_t            r;
    logic [IDX_W-1:0] i;
    r = '{found: 1'b0, idx: '0};
    for (int k = NUM_REQ; k >= 1; k--) begin
      i = last + IDX_W'(k);
      if (req[i]) r = '{found: 1'b1, idx: i};
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr4_ctrl_dec.sv
// 2-to-4 one-hot decoder with enable; drives the grant lines.
// Ports: in (binary index), en (enable), out (one-hot or zero).
module decoder_2to4 (
  input  logic [1:0] in,
  input  logic       en,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (en) begin
      unique case (1'b1)
        (in == 2'd0): out = 4'b0001;
        (in == 2'd1): out = 4'b0010;
        (in == 2'd2): out = 4'b0100;
        (in == 2'd3): out = 4'b1000;
        default:      out = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/arb_rr4_ctrl.sv
// Round-robin arbiter with grant lock and hold-limit timeout.
// Ports: clk, rst_n, arb_en, req[4] in; grant[4], grant_idx, busy, timeout out.
module arb_rr4_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout
);

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [IDX_W-1:0] last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             to_q, to_n;

  pick_t pick_idle;
  pick_t pick_hand;
  logic  rel;
  logic  hit_max;

  assign pick_idle = rr_pick(req, last_q);
  // On handover the pointer becomes the old owner.
  assign pick_hand = rr_pick(req, idx_q);
  assign rel       = ~req[idx_q];
  assign hit_max   = req[idx_q] && (cnt_q == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      to_q    <= to_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    to_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_en && pick_idle.found) begin
          state_n = GRANT;
          idx_n   = pick_idle.idx;
          cnt_n   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel || hit_max) begin
          last_n = idx_q;
          to_n   = hit_max;
          if (arb_en && pick_hand.found) begin
            idx_n = pick_hand.idx;
            cnt_n = CNT_W'(1);
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state_q == GRANT);
  assign grant_idx = idx_q;
  assign timeout   = to_q;

  decoder_2to4 u_dec (
    .in  (idx_q),
    .en  (busy),
    .out (grant)
  );

endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// Bench for arb_rr4_ctrl: directed vector table, rotation
// sequence, and random traffic against a behavioural model.
module tb_arb_rr4_ctrl;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic       arb_en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  arb_rr4_ctrl #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  localparam int NV = 30;
  vec_t vt[NV];

  // Behavioural model: owner number (-1 = none), pointer, hold count.
  int m_own;
  int m_ptr;
  int m_cnt;
  bit m_to;

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_own = -1; m_ptr = 3; m_cnt = 0; m_to = 0;
    end else if (m_own < 0) begin
      m_to = 0;
      w = pick(req, m_ptr);
      if (arb_en && w >= 0) begin
        m_own = w; m_cnt = 1;
      end
    end else begin
      m_to = req[m_own] && (m_cnt == MH);
      if (!req[m_own] || m_to) begin
        m_ptr = m_own;
        w = pick(req, m_ptr);
        if (arb_en && w >= 0) begin
          m_own = w; m_cnt = 1;
        end else begin
          m_own = -1; m_cnt = 0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic chk(string nm, int cyc, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(logic r, logic e, logic [3:0] q);
    rst_n  = r;
    arb_en = e;
    req    = q;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] eg;
    logic [1:0] ei;
    logic       r_r;
    logic       r_e;

    clk = 0; rst_n = 0; arb_en = 0; req = '0;
    m_own = -1; m_ptr = 3; m_cnt = 0; m_to = 0;

    vt[0]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[15] = '{1'b1, 1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[16] = '{1'b1, 1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[18] = '{1'b1, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[19] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[20] = '{1'b1, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[21] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[22] = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[23] = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[24] = '{1'b0, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[25] = '{1'b1, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[26] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[27] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[28] = '{1'b1, 1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[29] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst_n, vt[i].en, vt[i].req);
      chk("vec_grant", i, 8'(grant), 8'(vt[i].g));
      chk("vec_idx", i, 8'(grant_idx), 8'(vt[i].idx));
      chk("vec_busy", i, 8'(busy), 8'(vt[i].busy));
      chk("vec_timeout", i, 8'(timeout), 8'(vt[i].to));
    end

    // All four requesting: owners rotate every MH cycles.
    step(1'b0, 1'b1, 4'b0000);
    for (int c = 0; c < 5 * MH; c++) begin
      step(1'b1, 1'b1, 4'b1111);
      eg = 4'b0001 << ((c / MH) % 4);
      chk("rot_grant", c, 8'(grant), 8'(eg));
      chk("rot_busy", c, 8'(busy), 8'd1);
      chk("rot_timeout", c, 8'(timeout),
          8'((c > 0) && (c % MH == 0)));
    end

    // Random traffic against the model.
    step(1'b0, 1'b1, 4'b0000);
    rq = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 99) < 15) rq[b] = ~rq[b];
      end
      r_r = ($urandom_range(0, 99) != 0);
      r_e = ($urandom_range(0, 99) >= 15);
      step(r_r, r_e, rq);
      eg = (m_own < 0) ? 4'b0000 : 4'(4'b0001 << m_own);
      ei = (m_own < 0) ? 2'd0 : 2'(m_own);
      chk("rnd_grant", c, 8'(grant), 8'(eg));
      chk("rnd_idx", c, 8'(grant_idx), 8'(ei));
      chk("rnd_busy", c, 8'(busy), 8'(m_own >= 0));
      chk("rnd_timeout", c, 8'(timeout), 8'(m_to));
      chk("rnd_onehot", c, 8'($countones(grant) <= 1), 8'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
